// File: rtl/gallery_pkg.sv
// Shared types and defaults for the gallery navigation controller.
package gallery_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSeekFwd,
    StSeekBwd,
    StEmpty
  } gallery_state_t;

  localparam int unsigned GALLERY_NUM_IMAGES = 4;

endpackage

// File: rtl/gallery_probe_step.sv
// Combinational next-probe step: direction, modulo-NUM_IMAGES wrap, boundary stop and
// seek-start detection. Boundary behaviour depends on GALLERY_WRAP_EN.
module gallery_probe_step #(
  parameter int unsigned NUM_IMAGES = 4,
  parameter int unsigned IDX_W      = $clog2(NUM_IMAGES)
) (
  input  logic [IDX_W-1:0] probe_i,
  input  logic [IDX_W-1:0] start_i,
  input  logic             fwd_i,
  input  logic             force_wrap_i,
  output logic [IDX_W-1:0] next_o,
  output logic             stop_o,
  output logic             at_start_o
);

`ifdef GALLERY_WRAP_EN
  localparam bit WrapAll = 1'b1;
`else
  localparam bit WrapAll = 1'b0;
`endif

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_IMAGES - 1);

  logic crossing;

  always_comb begin
    next_o   = '0;
    crossing = 1'b0;
    if (fwd_i) begin
      crossing = (probe_i == LastIdx);
      next_o   = crossing ? '0 : probe_i + 1'b1;
    end else begin
      crossing = (probe_i == '0);
      next_o   = crossing ? LastIdx : probe_i - 1'b1;
    end
  end

  // Post-delete seeks always wrap so they land on a survivor.
  assign stop_o     = crossing & ~(WrapAll | force_wrap_i);
  assign at_start_o = (next_o == start_i);

endmodule

// File: rtl/gallery_nav.sv
// Gallery navigation controller: owns the displayed index and per-slot alive mask.
// Optional macro GALLERY_WRAP_EN makes next/prev wrap around the ends.
module gallery_nav
  import gallery_pkg::*;
#(
  parameter int unsigned NUM_IMAGES = GALLERY_NUM_IMAGES,
  parameter int unsigned IDX_W      = $clog2(NUM_IMAGES)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  next_pulse,
  input  logic                  prev_pulse,
  input  logic                  delete_pulse,
  input  logic                  restore_pulse,
  output logic [IDX_W-1:0]      image_index,
  output logic                  image_valid,
  output logic                  busy,
  output logic [NUM_IMAGES-1:0] alive_mask,
  output logic [IDX_W:0]        alive_count
);

  localparam logic [IDX_W:0] CountFull = (IDX_W + 1)'(NUM_IMAGES);
  localparam logic [IDX_W:0] CountOne  = (IDX_W + 1)'(1);

  gallery_state_t   state_q;
  logic [IDX_W-1:0] probe_q;
  logic             wrap_q;

  logic [IDX_W-1:0] step_probe;
  logic             step_fwd;
  logic             step_wrap;
  logic [IDX_W-1:0] step_next;
  logic             step_stop;
  logic             step_at_start;

  // In idle the stepper computes the first probe from the current index; while seeking
  // it advances the stored probe. The index never moves mid-seek, so it is the start.
  always_comb begin
    step_probe = image_index;
    step_fwd   = delete_pulse | next_pulse;
    step_wrap  = delete_pulse;
    if (state_q != StIdle) begin
      step_probe = probe_q;
      step_fwd   = (state_q == StSeekFwd);
      step_wrap  = wrap_q;
    end
  end

  gallery_probe_step #(
    .NUM_IMAGES (NUM_IMAGES),
    .IDX_W      (IDX_W)
  ) u_probe_step (
    .probe_i      (step_probe),
    .start_i      (image_index),
    .fwd_i        (step_fwd),
    .force_wrap_i (step_wrap),
    .next_o       (step_next),
    .stop_o       (step_stop),
    .at_start_o   (step_at_start)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      probe_q     <= '0;
      wrap_q      <= 1'b0;
      image_index <= '0;
      image_valid <= 1'b1;
      busy        <= 1'b0;
      alive_mask  <= '1;
      alive_count <= CountFull;
    end else if (restore_pulse) begin
      if (state_q == StEmpty) begin
        image_index <= '0;
      end
      state_q     <= StIdle;
      image_valid <= 1'b1;
      busy        <= 1'b0;
      alive_mask  <= '1;
      alive_count <= CountFull;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (delete_pulse) begin
            alive_mask[image_index] <= 1'b0;
            alive_count             <= alive_count - 1'b1;
            if (alive_count == CountOne) begin
              state_q     <= StEmpty;
              image_valid <= 1'b0;
            end else begin
              probe_q <= step_next;
              wrap_q  <= 1'b1;
              busy    <= 1'b1;
              state_q <= StSeekFwd;
            end
          end else if ((next_pulse || prev_pulse) && !step_stop) begin
            probe_q <= step_next;
            wrap_q  <= 1'b0;
            busy    <= 1'b1;
            state_q <= next_pulse ? StSeekFwd : StSeekBwd;
          end
        end
        StSeekFwd, StSeekBwd: begin
          if (alive_mask[probe_q]) begin
            image_index <= probe_q;
            busy        <= 1'b0;
            state_q     <= StIdle;
          end else if (step_stop || step_at_start) begin
            busy    <= 1'b0;
            state_q <= StIdle;
          end else begin
            probe_q <= step_next;
          end
        end
        StEmpty: begin
          state_q <= StEmpty;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gallery_nav.sv
// Self-checking bench for gallery_nav: per-cycle transaction-level model plus literal checks.
module tb_gallery_nav;

  localparam int N = 4;
  localparam int W = 2;
`ifdef GALLERY_WRAP_EN
  localparam bit Wrap = 1'b1;
`else
  localparam bit Wrap = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic         next_pulse, prev_pulse, delete_pulse, restore_pulse;
  logic [W-1:0] image_index;
  logic         image_valid;
  logic         busy;
  logic [N-1:0] alive_mask;
  logic [W:0]   alive_count;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  gallery_nav #(
    .NUM_IMAGES (N),
    .IDX_W      (W)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .next_pulse    (next_pulse),
    .prev_pulse    (prev_pulse),
    .delete_pulse  (delete_pulse),
    .restore_pulse (restore_pulse),
    .image_index   (image_index),
    .image_valid   (image_valid),
    .busy          (busy),
    .alive_mask    (alive_mask),
    .alive_count   (alive_count)
  );

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Number of busy cycles for a seek, and where it lands (-1: index unchanged).
  function automatic int seek_len(input int from, input int dir, input bit wrap,
                                  input logic [N-1:0] mask, output int tgt);
    int avail;
    int s;
    avail = wrap ? N - 1 : (dir > 0 ? N - 1 - from : from);
    tgt   = -1;
    for (int k = 1; k <= avail; k++) begin
      s = ((from + dir * k) % N + N) % N;
      if (mask[s]) begin
        tgt = s;
        return k;
      end
    end
    return avail;
  endfunction

  // Model state
  int           m_idx, m_cnt, m_left, m_tgt;
  logic [N-1:0] m_mask;
  bit           m_valid, m_empty;

  initial begin
    bit s_rn, s_n, s_p, s_d, s_r;
    m_idx = 0; m_cnt = N; m_left = 0; m_tgt = -1;
    m_mask = '1; m_valid = 1'b1; m_empty = 1'b0;
    forever begin
      @(posedge clk);
      s_rn = reset_n; s_n = next_pulse; s_p = prev_pulse;
      s_d = delete_pulse; s_r = restore_pulse;
      if (!s_rn) begin
        m_idx = 0; m_cnt = N; m_left = 0; m_mask = '1; m_valid = 1'b1; m_empty = 1'b0;
      end else if (s_r) begin
        if (m_empty) m_idx = 0;
        m_cnt = N; m_left = 0; m_mask = '1; m_valid = 1'b1; m_empty = 1'b0;
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0 && m_tgt >= 0) m_idx = m_tgt;
      end else if (m_empty) begin
        m_left = 0;
      end else if (s_d) begin
        m_mask[m_idx] = 1'b0;
        m_cnt--;
        if (m_cnt == 0) begin
          m_empty = 1'b1;
          m_valid = 1'b0;
        end else begin
          m_left = seek_len(m_idx, 1, 1'b1, m_mask, m_tgt);
        end
      end else if (s_n) begin
        m_left = seek_len(m_idx, 1, Wrap, m_mask, m_tgt);
      end else if (s_p) begin
        m_left = seek_len(m_idx, -1, Wrap, m_mask, m_tgt);
      end
      #1;
      check("model_index", int'(image_index), m_idx);
      check("model_valid", int'(image_valid), int'(m_valid));
      check("model_busy", int'(busy), int'(m_left > 0));
      check("model_mask", int'(alive_mask), int'(m_mask));
      check("model_count", int'(alive_count), m_cnt);
    end
  end

  task automatic pulse(input bit n, input bit p, input bit d, input bit r);
    @(negedge clk);
    next_pulse = n; prev_pulse = p; delete_pulse = d; restore_pulse = r;
    @(posedge clk);
    #1;
    next_pulse = 1'b0; prev_pulse = 1'b0; delete_pulse = 1'b0; restore_pulse = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3 * N && busy; i++) begin
      @(posedge clk);
      #1;
    end
    check("seek_done", int'(busy), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    next_pulse = 1'b0; prev_pulse = 1'b0; delete_pulse = 1'b0; restore_pulse = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_index", int'(image_index), 0);
    check("rst_mask", int'(alive_mask), 15);
    check("rst_count", int'(alive_count), 4);
    check("rst_valid", int'(image_valid), 1);
    check("rst_busy", int'(busy), 0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 1; i <= 3; i++) begin
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      check("next_busy", int'(busy), 1);
      wait_idle();
      check("next_index", int'(image_index), i);
    end

    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    check("del3_mask", int'(alive_mask), 7);
    check("del3_count", int'(alive_count), 3);
    wait_idle();
    check("del3_index", int'(image_index), 0);

    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    wait_idle();
    check("prev_from0", int'(image_index), Wrap ? 2 : 0);

    do_reset();
    for (int i = 0; i < 4; i++) begin
      pulse(1'b0, 1'b0, 1'b1, 1'b0);
      wait_idle();
    end
    check("empty_count", int'(alive_count), 0);
    check("empty_valid", int'(image_valid), 0);
    check("empty_index", int'(image_index), 3);
    check("empty_mask", int'(alive_mask), 0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("empty_hold_count", int'(alive_count), 0);
    check("empty_hold_index", int'(image_index), 3);
    check("empty_hold_valid", int'(image_valid), 0);

    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("restore_mask", int'(alive_mask), 15);
    check("restore_index", int'(image_index), 0);
    check("restore_valid", int'(image_valid), 1);
    check("restore_count", int'(alive_count), 4);

    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    wait_idle();
    check("next_to1", int'(image_index), 1);
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    wait_idle();
    check("next_over_prev", int'(image_index), 2);
    pulse(1'b1, 1'b0, 1'b1, 1'b0);
    check("del_over_next_mask", int'(alive_mask), 11);
    check("del_over_next_count", int'(alive_count), 3);
    wait_idle();
    check("del_over_next_index", int'(image_index), 3);

    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    wait_idle();
    check("next_at_last", int'(image_index), Wrap ? 0 : 3);
    do_reset();
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    wait_idle();
    check("prev_at_first", int'(image_index), Wrap ? 3 : 0);

    // Build mask 1001 and seek forward over two dead slots
    do_reset();
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    wait_idle();
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    wait_idle();
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    wait_idle();
    check("mask_1001", int'(alive_mask), 9);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    wait_idle();
    check("prev_skip_to0", int'(image_index), 0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    wait_idle();
    check("busy_drop_index", int'(image_index), 3);
    repeat (3) @(posedge clk);
    #1;
    check("busy_drop_hold", int'(image_index), 3);

    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    wait_idle();
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("midseek_rst_index", int'(image_index), 0);
    check("midseek_rst_mask", int'(alive_mask), 15);
    check("midseek_rst_busy", int'(busy), 0);
    check("midseek_rst_count", int'(alive_count), 4);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("midseek_rst_hold", int'(image_index), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
